// File: rtl/sys_ctrl_burst.sv
// REF-domain system controller: decodes UART command frames into register-file,
// ALU and TX-handshake activity, with burst reads, inter-byte timeout and error flag.
module sys_ctrl_burst #(
    parameter int DATA_WIDTH     = 8,
    parameter int RF_ADDR        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VLD,
    input  logic                    TX_BUSY,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VLD,
    output logic                    RF_WrEn,
    output logic                    RF_RdEn,
    output logic [RF_ADDR-1:0]      RF_Address,
    output logic [DATA_WIDTH-1:0]   RF_WrData,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    output logic                    ALU_EN,
    output logic [3:0]              ALU_FUN,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    output logic                    CLKG_EN,
    output logic                    CLKDIV_EN,
    output logic                    FRAME_ERR
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_NOP = DATA_WIDTH'(8'hDD);
    localparam logic [DATA_WIDTH-1:0] CMD_BR  = DATA_WIDTH'(8'hEE);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, BR_ADDR, BR_CNT,
        RD_ISSUE, RD_WAIT, ALU_WAIT, TX_SEND, TX_HI, TX_LO
    } state_t;

    state_t                  state_q, state_n;
    logic [RF_ADDR-1:0]      addr_q, addr_n;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_n;
    logic [2*DATA_WIDTH-1:0] res_q, res_n;
    logic                    hi_pend_q, hi_pend_n;
    logic                    burst_q, burst_n;
    logic [TW-1:0]           timer_q, timer_n;
    logic                    timed;

    logic [DATA_WIDTH-1:0]   tx_data_n;
    logic                    tx_vld_n, wr_en_n, rd_en_n, ferr_n;
    logic [RF_ADDR-1:0]      rf_addr_n;
    logic [DATA_WIDTH-1:0]   wr_data_n;
    logic                    alu_en_n, clkg_n;
    logic [3:0]              alu_fun_n;

    always_comb begin
        state_n   = state_q;
        addr_n    = addr_q;
        cnt_n     = cnt_q;
        res_n     = res_q;
        hi_pend_n = hi_pend_q;
        burst_n   = burst_q;
        tx_data_n = TX_DATA;
        tx_vld_n  = 1'b0;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        ferr_n    = 1'b0;
        rf_addr_n = RF_Address;
        wr_data_n = RF_WrData;
        alu_en_n  = ALU_EN;
        alu_fun_n = ALU_FUN;
        clkg_n    = CLKG_EN;
        timed     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (RX_VLD) begin
                    unique case (1'b1)
                        RX_DATA == CMD_WR:  state_n = WR_ADDR;
                        RX_DATA == CMD_RD:  state_n = RD_ADDR;
                        RX_DATA == CMD_ALU: state_n = OPA;
                        RX_DATA == CMD_NOP: state_n = FUN;
                        RX_DATA == CMD_BR:  state_n = BR_ADDR;
                        default:            ferr_n  = 1'b1;
                    endcase
                end
            end
            WR_ADDR: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    addr_n  = RX_DATA[RF_ADDR-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    wr_en_n   = 1'b1;
                    rf_addr_n = addr_q;
                    wr_data_n = RX_DATA;
                    state_n   = IDLE;
                end
            end
            RD_ADDR: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    addr_n  = RX_DATA[RF_ADDR-1:0];
                    burst_n = 1'b0;
                    state_n = RD_ISSUE;
                end
            end
            OPA: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    wr_en_n   = 1'b1;
                    rf_addr_n = '0;
                    wr_data_n = RX_DATA;
                    state_n   = OPB;
                end
            end
            OPB: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    wr_en_n   = 1'b1;
                    rf_addr_n = RF_ADDR'(1);
                    wr_data_n = RX_DATA;
                    state_n   = FUN;
                end
            end
            FUN: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    alu_fun_n = RX_DATA[3:0];
                    alu_en_n  = 1'b1;
                    clkg_n    = 1'b1;
                    state_n   = ALU_WAIT;
                end
            end
            BR_ADDR: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    addr_n  = RX_DATA[RF_ADDR-1:0];
                    state_n = BR_CNT;
                end
            end
            BR_CNT: begin
                timed = 1'b1;
                if (RX_VLD) begin
                    if (RX_DATA == '0) begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = RX_DATA;
                        burst_n = 1'b1;
                        state_n = RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                rd_en_n   = 1'b1;
                rf_addr_n = addr_q;
                state_n   = RD_WAIT;
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    res_n     = {{DATA_WIDTH{1'b0}}, RF_RdData};
                    hi_pend_n = 1'b0;
                    state_n   = TX_SEND;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    res_n     = ALU_OUT;
                    hi_pend_n = 1'b1;
                    burst_n   = 1'b0;
                    alu_en_n  = 1'b0;
                    clkg_n    = 1'b0;
                    state_n   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!TX_BUSY) begin
                    tx_vld_n  = 1'b1;
                    tx_data_n = res_q[DATA_WIDTH-1:0];
                    state_n   = TX_HI;
                end
            end
            TX_HI: begin
                timed = 1'b1;
                if (TX_BUSY) state_n = TX_LO;
            end
            TX_LO: begin
                timed = 1'b1;
                if (!TX_BUSY) begin
                    if (hi_pend_q) begin
                        hi_pend_n = 1'b0;
                        res_n     = res_q >> DATA_WIDTH;
                        state_n   = TX_SEND;
                    end else if (burst_q && cnt_q > DATA_WIDTH'(1)) begin
                        cnt_n   = cnt_q - DATA_WIDTH'(1);
                        addr_n  = addr_q + RF_ADDR'(1);
                        state_n = RD_ISSUE;
                    end else begin
                        burst_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Silence for the full window abandons the frame
        if (timed && TIMEOUT_CYCLES != 0 && timer_q == TMAX &&
            state_n == state_q) begin
            state_n   = IDLE;
            ferr_n    = 1'b1;
            alu_en_n  = 1'b0;
            clkg_n    = 1'b0;
            burst_n   = 1'b0;
            hi_pend_n = 1'b0;
        end

        timer_n = (state_n != state_q || !timed) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            hi_pend_q  <= 1'b0;
            burst_q    <= 1'b0;
            timer_q    <= '0;
            TX_DATA    <= '0;
            TX_VLD     <= 1'b0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLKG_EN    <= 1'b0;
            CLKDIV_EN  <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            cnt_q      <= cnt_n;
            res_q      <= res_n;
            hi_pend_q  <= hi_pend_n;
            burst_q    <= burst_n;
            timer_q    <= timer_n;
            TX_DATA    <= tx_data_n;
            TX_VLD     <= tx_vld_n;
            RF_WrEn    <= wr_en_n;
            RF_RdEn    <= rd_en_n;
            RF_Address <= rf_addr_n;
            RF_WrData  <= wr_data_n;
            ALU_EN     <= alu_en_n;
            ALU_FUN    <= alu_fun_n;
            CLKG_EN    <= clkg_n;
            CLKDIV_EN  <= 1'b1;
            FRAME_ERR  <= ferr_n;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed + randomized bench for sys_ctrl_burst with RF, ALU and UART TX models
// and a register-level reference of expected responses.
module tb_sys_ctrl_burst;

    localparam int DW = 8;
    localparam int RA = 4;
    localparam int T  = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] RX_DATA = '0;
    logic          RX_VLD = 1'b0;
    logic          TX_BUSY = 1'b0;
    logic [DW-1:0] TX_DATA;
    logic          TX_VLD;
    logic          RF_WrEn, RF_RdEn;
    logic [RA-1:0] RF_Address;
    logic [DW-1:0] RF_WrData;
    logic [DW-1:0] RF_RdData = '0;
    logic          RF_RdData_VLD = 1'b0;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic          ALU_OUT_VLD = 1'b0;
    logic          CLKG_EN, CLKDIV_EN, FRAME_ERR;

    sys_ctrl_burst #(.DATA_WIDTH(DW), .RF_ADDR(RA), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VLD(RX_VLD),
        .TX_BUSY(TX_BUSY), .TX_DATA(TX_DATA), .TX_VLD(TX_VLD),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData),
        .RF_RdData_VLD(RF_RdData_VLD), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .CLKG_EN(CLKG_EN),
        .CLKDIV_EN(CLKDIV_EN), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_cyc = 0;

    logic [DW-1:0] env_rf [16];
    logic [DW-1:0] ref_rf [16];

    logic [RA-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [RA-1:0] ra_q[$];
    logic [DW-1:0] tx_q[$];
    int ferr_cnt = 0;
    int ferr_cyc = 0;
    int alu_seen = 0;
    int tx_overlap = 0;
    logic clkg_ok = 1'b0;

    function automatic logic [15:0] alu_calc(input logic [3:0] f,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            default: return {8'h00, a & b};
        endcase
    endfunction

    initial forever @(posedge CLK) cyc++;

    // Register file: 2-cycle read latency
    initial begin
        int rd_cnt = 0;
        logic [RA-1:0] rd_a = '0;
        forever begin
            @(negedge CLK);
            RF_RdData_VLD = 1'b0;
            if (RF_WrEn) env_rf[RF_Address] = RF_WrData;
            if (rd_cnt != 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    RF_RdData = env_rf[rd_a];
                    RF_RdData_VLD = 1'b1;
                end
            end
            if (RF_RdEn) begin
                rd_a = RF_Address;
                rd_cnt = 2;
            end
        end
    end

    // ALU: operands from registers 0 and 1, random latency
    initial begin
        int dly = 0;
        bit done = 0;
        forever begin
            @(negedge CLK);
            ALU_OUT_VLD = 1'b0;
            if (!ALU_EN) done = 0;
            else if (!done) begin
                if (dly == 0) dly = $urandom_range(1, 4);
                else begin
                    dly--;
                    if (dly == 0) begin
                        ALU_OUT = alu_calc(ALU_FUN, env_rf[0], env_rf[1]);
                        ALU_OUT_VLD = 1'b1;
                        clkg_ok = CLKG_EN & ALU_EN;
                        done = 1;
                    end
                end
            end
        end
    end

    // UART TX: busy for a few cycles after each byte
    initial begin
        int left = 0;
        forever begin
            @(negedge CLK);
            if (TX_VLD) begin
                tx_q.push_back(TX_DATA);
                if (TX_BUSY) tx_overlap++;
            end
            if (left > 0) begin
                left--;
                if (left == 0) TX_BUSY = 1'b0;
            end else if (TX_VLD) begin
                TX_BUSY = 1'b1;
                left = $urandom_range(2, 5);
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (RF_WrEn) begin
            wa_q.push_back(RF_Address);
            wd_q.push_back(RF_WrData);
        end
        if (RF_RdEn) ra_q.push_back(RF_Address);
        if (FRAME_ERR) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (ALU_EN) alu_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        tx_q.delete();
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_VLD = 1'b1;
        last_rx_cyc = cyc;
        @(negedge CLK);
        RX_VLD = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k = 0;
        while (tx_q.size() < n && k < 4000) begin
            @(negedge CLK);
            k++;
        end
        k = 0;
        while (TX_BUSY && k < 100) begin
            @(negedge CLK);
            k++;
        end
        repeat (4) @(negedge CLK);
        check({tag, "_txcnt"}, tx_q.size(), n);
    endtask

    task automatic cmd_wr(input logic [7:0] a, input logic [7:0] d);
        clear_q();
        send(8'hAA); send(a); send(d);
        repeat (3) @(negedge CLK);
        ref_rf[a[3:0]] = d;
        check("wr_cnt", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            check("wr_addr", wa_q[0], a[3:0]);
            check("wr_data", wd_q[0], d);
        end
        check("wr_notx", tx_q.size(), 0);
    endtask

    task automatic cmd_rd(input logic [7:0] a);
        clear_q();
        send(8'hBB); send(a);
        wait_tx(1, "rd");
        check("rd_cnt", ra_q.size(), 1);
        if (ra_q.size() > 0) check("rd_addr", ra_q[0], a[3:0]);
        if (tx_q.size() > 0) check("rd_byte", tx_q[0], ref_rf[a[3:0]]);
    endtask

    task automatic cmd_alu(input bit with_ops, input logic [7:0] x,
                           input logic [7:0] y, input logic [3:0] f);
        logic [15:0] r;
        clear_q();
        clkg_ok = 1'b0;
        if (with_ops) begin
            send(8'hCC); send(x); send(y);
            ref_rf[0] = x;
            ref_rf[1] = y;
        end else begin
            send(8'hDD);
        end
        send({4'h0, f});
        r = alu_calc(f, ref_rf[0], ref_rf[1]);
        wait_tx(2, "alu");
        if (with_ops) begin
            check("alu_wrcnt", wa_q.size(), 2);
            if (wa_q.size() == 2) begin
                check("alu_wa0", {wa_q[0], wd_q[0]}, {4'd0, x});
                check("alu_wa1", {wa_q[1], wd_q[1]}, {4'd1, y});
            end
        end
        check("alu_clkg_at_vld", clkg_ok, 1'b1);
        check("alu_en_off", {ALU_EN, CLKG_EN}, 2'b00);
        if (tx_q.size() == 2) begin
            check("alu_lo", tx_q[0], r[7:0]);
            check("alu_hi", tx_q[1], r[15:8]);
        end
    endtask

    task automatic cmd_burst(input logic [7:0] a, input int c);
        clear_q();
        tx_overlap = 0;
        send(8'hEE); send(a); send(8'(c));
        wait_tx(c, "br");
        check("br_rdcnt", ra_q.size(), c);
        for (int i = 0; i < c && i < ra_q.size() && i < tx_q.size(); i++) begin
            logic [3:0] ea;
            ea = 4'(a + 8'(i));
            check("br_addr", ra_q[i], ea);
            check("br_byte", tx_q[i], ref_rf[ea]);
        end
        check("br_overlap", tx_overlap, 0);
    endtask

    initial begin
        int f0, a0, t0, k, dt;
        for (int i = 0; i < 16; i++) begin
            env_rf[i] = 8'($urandom);
            ref_rf[i] = env_rf[i];
        end

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("reset_outs",
              {TX_DATA, TX_VLD, RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
               ALU_EN, ALU_FUN, CLKG_EN, CLKDIV_EN, FRAME_ERR}, 0);
        RST = 1'b0;
        check("clkdiv_held", CLKDIV_EN, 1'b0);
        @(negedge CLK);
        check("clkdiv_on", CLKDIV_EN, 1'b1);

        cmd_wr(8'h05, 8'h3C);
        cmd_rd(8'h05);
        cmd_alu(1, 8'h10, 8'h20, 4'h0);
        cmd_burst(8'h0E, 3);

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 4))
                0: cmd_wr(8'($urandom), 8'($urandom));
                1: cmd_rd(8'($urandom_range(0, 15)));
                2: cmd_alu(1, 8'($urandom), 8'($urandom),
                           4'($urandom_range(0, 3)));
                3: cmd_alu(0, 8'h00, 8'h00, 4'($urandom_range(0, 3)));
                default: cmd_burst(8'($urandom), $urandom_range(1, 4));
            endcase
        end

        // inter-byte timeout
        clear_q();
        f0 = ferr_cnt;
        send(8'hAA);
        send(8'h05);
        t0 = last_rx_cyc;
        k = 0;
        while (ferr_cnt == f0 && k < 3 * T) begin
            @(negedge CLK);
            k++;
        end
        repeat (3) @(negedge CLK);
        check("to_ferr_cnt", ferr_cnt, f0 + 1);
        dt = ferr_cyc - t0;
        check("to_window", (dt >= T && dt <= T + 2), 1'b1);
        check("to_no_wr", wa_q.size(), 0);
        cmd_rd(8'h05);

        // bad command
        clear_q();
        f0 = ferr_cnt;
        a0 = alu_seen;
        send(8'h77);
        repeat (4) @(negedge CLK);
        check("bad_ferr", ferr_cnt, f0 + 1);
        check("bad_quiet", wa_q.size() + ra_q.size() + tx_q.size(), 0);
        check("bad_noalu", alu_seen, a0);

        // burst with zero count
        clear_q();
        f0 = ferr_cnt;
        send(8'hEE); send(8'h03); send(8'h00);
        repeat (4) @(negedge CLK);
        check("br0_ferr", ferr_cnt, f0 + 1);
        check("br0_quiet", ra_q.size() + tx_q.size(), 0);

        // reset mid-frame: aborted silently
        clear_q();
        f0 = ferr_cnt;
        send(8'hAA); send(8'h07);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_clkdiv", CLKDIV_EN, 1'b0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_noferr", ferr_cnt, f0);
        check("rst_nowr", wa_q.size(), 0);
        check("rst_clkdiv_on", CLKDIV_EN, 1'b1);
        cmd_rd(8'h07);
        cmd_burst(8'h0F, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
